// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Next-PC controller for the program counter register. Each cycle it decides
//   whether the PC advances sequentially, holds, or is redirected by an ID-stage
//   jump or an EX-stage taken branch. A redirect that arrives while the pipeline
//   is stalled is stored and applied when the stall releases.
//
// Ports
//   clock            rising-edge system clock
//   reset_n          asynchronous active-low reset
//   pc_cur           current PC register value
//   hazard_stall     load-use stall request
//   imem_ready       instruction memory accepts a new fetch address
//   jump_valid       unconditional jump resolved in ID
//   jump_target      jump destination
//   branch_taken     taken branch resolved in EX
//   branch_target    branch destination
//   pc_next          value for the PC register input (registered)
//   pc_write         PC write enable (registered)
//   flush_if         squash IF/ID instruction, one-cycle pulse (registered)
//   flush_id         squash ID/EX instruction, one-cycle pulse (registered)
//   redirect_pending a stored redirect awaits stall release (registered)
//   stall_count      saturating count of held cycles since reset (registered)
//
// The PC register samples these outputs on the falling edge, so a decision made
// at rising edge k takes effect within cycle k.

module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned INSTR_BYTES    = 4,
    parameter int unsigned STARTUP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] pc_cur,
    input  logic        hazard_stall,
    input  logic        imem_ready,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_next,
    output logic        pc_write,
    output logic        flush_if,
    output logic        flush_id,
    output logic        redirect_pending,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        ST_STARTUP    = 2'd0,
        ST_RUN        = 2'd1,
        ST_HOLD       = 2'd2,
        ST_HOLD_REDIR = 2'd3
    } state_t;

    localparam logic [3:0]  STARTUP_LAST = 4'(STARTUP_CYCLES - 1);
    localparam logic [31:0] PC_STEP      = 32'(INSTR_BYTES);

    state_t      state_r,          state_s;
    logic [3:0]  startup_cnt_r,    startup_cnt_s;
    logic [31:0] stored_target_r,  stored_target_s;
    logic        stored_branch_r,  stored_branch_s;
    logic [31:0] pc_next_r,        pc_next_s;
    logic        pc_write_r,       pc_write_s;
    logic        flush_if_r,       flush_if_s;
    logic        flush_id_r,       flush_id_s;
    logic        pending_r,        pending_s;
    logic [15:0] stall_count_r,    stall_count_s;
    logic        count_inc_s;
    logic        stall_s;
    logic [31:0] seq_pc_s;

    assign stall_s  = hazard_stall | ~imem_ready;
    // Natural 32-bit wrap: 0xFFFFFFFC + 4 = 0x00000000.
    assign seq_pc_s = pc_cur + PC_STEP;

    // Next-state and next-output decision for the sequencer.
    always_comb begin
        state_s         = state_r;
        startup_cnt_s   = startup_cnt_r;
        stored_target_s = stored_target_r;
        stored_branch_s = stored_branch_r;
        pc_next_s       = pc_next_r;
        pc_write_s      = 1'b0;
        flush_if_s      = 1'b0;
        flush_id_s      = 1'b0;
        pending_s       = pending_r;
        count_inc_s     = 1'b0;

        case (state_r)
            ST_STARTUP: begin
                // Redirects and stalls are ignored until the first fetch issues.
                if (startup_cnt_r == STARTUP_LAST) begin
                    pc_next_s     = RESET_VECTOR;
                    pc_write_s    = 1'b1;
                    startup_cnt_s = 4'd0;
                    state_s       = ST_RUN;
                end else begin
                    startup_cnt_s = startup_cnt_r + 4'd1;
                end
            end

            ST_RUN, ST_HOLD: begin
                if (!stall_s) begin
                    pc_write_s = 1'b1;
                    state_s    = ST_RUN;
                    if (branch_taken) begin
                        pc_next_s  = branch_target;
                        flush_if_s = 1'b1;
                        flush_id_s = 1'b1;
                    end else if (jump_valid) begin
                        pc_next_s  = jump_target;
                        flush_if_s = 1'b1;
                    end else begin
                        pc_next_s  = seq_pc_s;
                    end
                end else begin
                    count_inc_s = 1'b1;
                    if (branch_taken) begin
                        stored_target_s = branch_target;
                        stored_branch_s = 1'b1;
                        flush_if_s      = 1'b1;
                        flush_id_s      = 1'b1;
                        pending_s       = 1'b1;
                        state_s         = ST_HOLD_REDIR;
                    end else if (jump_valid) begin
                        stored_target_s = jump_target;
                        stored_branch_s = 1'b0;
                        flush_if_s      = 1'b1;
                        pending_s       = 1'b1;
                        state_s         = ST_HOLD_REDIR;
                    end else begin
                        state_s         = ST_HOLD;
                    end
                end
            end

            ST_HOLD_REDIR: begin
                if (!stall_s) begin
                    pc_write_s = 1'b1;
                    pending_s  = 1'b0;
                    state_s    = ST_RUN;
                    // A fresh EX branch is older than anything stored; a fresh
                    // ID jump is younger than the stored redirect and is dropped.
                    if (branch_taken) begin
                        pc_next_s  = branch_target;
                        flush_if_s = 1'b1;
                        flush_id_s = 1'b1;
                    end else begin
                        pc_next_s  = stored_target_r;
                    end
                end else begin
                    count_inc_s = 1'b1;
                    // A stored branch is never replaced; a stored jump yields to
                    // any newer redirect.
                    if (stored_branch_r) begin
                        stored_target_s = stored_target_r;
                    end else if (branch_taken) begin
                        stored_target_s = branch_target;
                        stored_branch_s = 1'b1;
                        flush_if_s      = 1'b1;
                        flush_id_s      = 1'b1;
                    end else if (jump_valid) begin
                        stored_target_s = jump_target;
                        flush_if_s      = 1'b1;
                    end else begin
                        stored_target_s = stored_target_r;
                    end
                end
            end

            default: begin
                state_s       = ST_STARTUP;
                startup_cnt_s = 4'd0;
                pending_s     = 1'b0;
            end
        endcase

        if (count_inc_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_s = stall_count_r + 16'd1;
        end else begin
            stall_count_s = stall_count_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_STARTUP;
            startup_cnt_r   <= 4'd0;
            stored_target_r <= 32'h0000_0000;
            stored_branch_r <= 1'b0;
            pc_next_r       <= RESET_VECTOR;
            pc_write_r      <= 1'b0;
            flush_if_r      <= 1'b0;
            flush_id_r      <= 1'b0;
            pending_r       <= 1'b0;
            stall_count_r   <= 16'd0;
        end else begin
            state_r         <= state_s;
            startup_cnt_r   <= startup_cnt_s;
            stored_target_r <= stored_target_s;
            stored_branch_r <= stored_branch_s;
            pc_next_r       <= pc_next_s;
            pc_write_r      <= pc_write_s;
            flush_if_r      <= flush_if_s;
            flush_id_r      <= flush_id_s;
            pending_r       <= pending_s;
            stall_count_r   <= stall_count_s;
        end
    end

    assign pc_next          = pc_next_r;
    assign pc_write         = pc_write_r;
    assign flush_if         = flush_if_r;
    assign flush_id         = flush_id_r;
    assign redirect_pending = pending_r;
    assign stall_count      = stall_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: table-driven cycle vectors with a scoreboard
// queue of expected outputs, plus a hand-written mid-operation reset sequence.

module tb_pc_sequencer;

    logic        clock;
    logic        reset_n;
    logic [31:0] pc_cur;
    logic        hazard_stall;
    logic        imem_ready;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        flush_if;
    logic        flush_id;
    logic        redirect_pending;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        w;
        logic        fif;
        logic        fid;
        logic        pend;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [31:0] pc_cur;
        logic        hz;
        logic        rdy;
        logic        jv;
        logic [31:0] jt;
        logic        bt;
        logic [31:0] btg;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    vec_t rst_vecs[$];
    exp_t sb[$];

    pc_sequencer #(
        .RESET_VECTOR   (32'h0000_0000),
        .INSTR_BYTES    (4),
        .STARTUP_CYCLES (2)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pc_cur           (pc_cur),
        .hazard_stall     (hazard_stall),
        .imem_ready       (imem_ready),
        .jump_valid       (jump_valid),
        .jump_target      (jump_target),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .pc_next          (pc_next),
        .pc_write         (pc_write),
        .flush_if         (flush_if),
        .flush_id         (flush_id),
        .redirect_pending (redirect_pending),
        .stall_count      (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [31:0] pcc, input logic hz, input logic rdy,
                                input logic jv, input logic [31:0] jt,
                                input logic bt, input logic [31:0] btg,
                                input logic [31:0] e_pc, input logic e_w,
                                input logic e_fif, input logic e_fid,
                                input logic e_pend, input logic [15:0] e_cnt);
        vec_t v;
        v.pc_cur = pcc; v.hz = hz; v.rdy = rdy; v.jv = jv; v.jt = jt;
        v.bt = bt; v.btg = btg;
        v.e.pc = e_pc; v.e.w = e_w; v.e.fif = e_fif; v.e.fid = e_fid;
        v.e.pend = e_pend; v.e.cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, req);
        end
    endtask

    task automatic compare_outputs(input int row, input exp_t e);
        check("pc_next",          row, pc_next,                  e.pc);
        check("pc_write",         row, {31'd0, pc_write},         {31'd0, e.w});
        check("flush_if",         row, {31'd0, flush_if},         {31'd0, e.fif});
        check("flush_id",         row, {31'd0, flush_id},         {31'd0, e.fid});
        check("redirect_pending", row, {31'd0, redirect_pending}, {31'd0, e.pend});
        check("stall_count",      row, {16'd0, stall_count},      {16'd0, e.cnt});
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then score the result.
    task automatic run_cycle(input int row, input vec_t v);
        exp_t e;
        pc_cur        = v.pc_cur;
        hazard_stall  = v.hz;
        imem_ready    = v.rdy;
        jump_valid    = v.jv;
        jump_target   = v.jt;
        branch_taken  = v.bt;
        branch_target = v.btg;
        sb.push_back(v.e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard row %0d: queue empty", row);
        end else begin
            e = sb.pop_front();
            compare_outputs(row, e);
        end
    endtask

    initial begin
        exp_t rst_e;
        rst_e.pc = 32'h0; rst_e.w = 1'b0; rst_e.fif = 1'b0; rst_e.fid = 1'b0;
        rst_e.pend = 1'b0; rst_e.cnt = 16'd0;

        //              pc_cur        hz    rdy   jv    jt            bt    btg           e_pc          w     fif   fid   pend  cnt
        vecs.push_back(mk(32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'd0));  // startup hold
        vecs.push_back(mk(32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 16'd0));  // reset vector
        vecs.push_back(mk(32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'h4,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'h8,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'hC,        1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'h20,       1'b0, 1'b1, 1'b1, 32'h200,      1'b1, 32'h100,      32'h100,      1'b1, 1'b1, 1'b1, 1'b0, 16'd0));  // branch beats jump
        vecs.push_back(mk(32'h100,      1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h104,      1'b1, 1'b0, 1'b0, 1'b0, 16'd0));  // flush ends
        vecs.push_back(mk(32'h30,       1'b0, 1'b1, 1'b1, 32'h200,      1'b0, 32'h0,        32'h200,      1'b1, 1'b1, 1'b0, 1'b0, 16'd0));  // jump: IF flush only
        vecs.push_back(mk(32'h40,       1'b1, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0,        32'h200,      1'b0, 1'b1, 1'b0, 1'b1, 16'd1));  // stall 1 + jump
        vecs.push_back(mk(32'h40,       1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h200,      1'b0, 1'b0, 1'b0, 1'b1, 16'd2));
        vecs.push_back(mk(32'h40,       1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h200,      1'b0, 1'b0, 1'b0, 1'b1, 16'd3));
        vecs.push_back(mk(32'h40,       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h80,       1'b1, 1'b0, 1'b0, 1'b0, 16'd3));  // release -> 0x80
        vecs.push_back(mk(32'h80,       1'b1, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0,        32'h80,       1'b0, 1'b1, 1'b0, 1'b1, 16'd4));  // store jump
        vecs.push_back(mk(32'h80,       1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h300,      32'h80,       1'b0, 1'b1, 1'b1, 1'b1, 16'd5));  // branch overwrites
        vecs.push_back(mk(32'h80,       1'b1, 1'b1, 1'b1, 32'h90,       1'b0, 32'h0,        32'h80,       1'b0, 1'b0, 1'b0, 1'b1, 16'd6));  // jump ignored
        vecs.push_back(mk(32'h80,       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h300,      1'b1, 1'b0, 1'b0, 1'b0, 16'd6));  // release -> 0x300
        vecs.push_back(mk(32'h300,      1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h300,      1'b0, 1'b0, 1'b0, 1'b0, 16'd7));  // imem busy
        vecs.push_back(mk(32'h300,      1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h300,      1'b0, 1'b0, 1'b0, 1'b0, 16'd8));
        vecs.push_back(mk(32'h300,      1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h304,      1'b1, 1'b0, 1'b0, 1'b0, 16'd8));  // HOLD release
        vecs.push_back(mk(32'h304,      1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h304,      1'b0, 1'b0, 1'b0, 1'b0, 16'd9));  // HOLD
        vecs.push_back(mk(32'h304,      1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h400,      32'h304,      1'b0, 1'b1, 1'b1, 1'b1, 16'd10)); // HOLD capture
        vecs.push_back(mk(32'h304,      1'b0, 1'b1, 1'b1, 32'h500,      1'b0, 32'h0,        32'h400,      1'b1, 1'b0, 1'b0, 1'b0, 16'd10)); // stored beats jump
        vecs.push_back(mk(32'h400,      1'b1, 1'b1, 1'b1, 32'h600,      1'b0, 32'h0,        32'h400,      1'b0, 1'b1, 1'b0, 1'b1, 16'd11));
        vecs.push_back(mk(32'h400,      1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h700,      32'h700,      1'b1, 1'b1, 1'b1, 1'b0, 16'd11)); // branch beats stored
        vecs.push_back(mk(32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 16'd11)); // wrap
        vecs.push_back(mk(32'h0,        1'b1, 1'b1, 1'b1, 32'h44,       1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 16'd12)); // into HOLD_REDIR

        // After a mid-operation reset: redirects and stall ignored during startup.
        rst_vecs.push_back(mk(32'h0,    1'b1, 1'b1, 1'b1, 32'h910,      1'b1, 32'h900,      32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        rst_vecs.push_back(mk(32'h0,    1'b0, 1'b1, 1'b1, 32'h910,      1'b1, 32'h900,      32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
        rst_vecs.push_back(mk(32'h0,    1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        1'b1, 1'b0, 1'b0, 1'b0, 16'd0));

        reset_n = 1'b0; pc_cur = 32'h0; hazard_stall = 1'b0; imem_ready = 1'b1;
        jump_valid = 1'b0; jump_target = 32'h0; branch_taken = 1'b0; branch_target = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        compare_outputs(-1, rst_e);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(i, vecs[i]);
        end

        // Asynchronous reset while a redirect is stored.
        reset_n = 1'b0;
        #1;
        compare_outputs(-2, rst_e);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < rst_vecs.size(); i++) begin
            run_cycle(100 + i, rst_vecs[i]);
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
